// File: rtl/register_bank_multi_nco_if.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_multi_nco_if
// Description : Byte-wide register bus between the I2C slave byte engine and
//               the NCO register bank.
//               master : drives addr / dataIn / writeEn, receives dataOut
//               slave  : receives addr / dataIn / writeEn, drives dataOut
// Revision    : 1.0 - initial release
// ============================================================================
interface register_bank_multi_nco_if;
  logic [7:0] addr;     // register address
  logic [7:0] dataIn;   // write data
  logic       writeEn;  // write strobe, one write per high cycle
  logic [7:0] dataOut;  // registered read data (1-cycle latency)

  modport master (output addr, output dataIn, output writeEn, input dataOut);
  modport slave  (input addr, input dataIn, input writeEn, output dataOut);
endinterface
`default_nettype wire

// File: rtl/register_bank_multi_nco.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_multi_nco
// Description : Register file holding NUM_CH NCO phase words (WORD_BYTES bytes
//               each, committed atomically on the LSB byte write), NUM_CTRL
//               8-bit control registers with update strobes and a read-only
//               pending-status register.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               bus (slave)     - addr / dataIn / writeEn in, dataOut out
//               sync_tick       - commit boundary (SYNC_COMMIT_EN builds only)
//               phase_words     - committed phase words, channel c at [c*W +: W]
//               phase_update    - one-cycle pulse per committed channel
//               ctrl_regs       - control registers, register k at [k*8 +: 8]
//               ctrl_update     - one-cycle pulse per written control register
// Options     : `define SYNC_COMMIT_EN to hold LSB-completed words pending
//               until sync_tick so several channels retune coherently.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank_multi_nco #(
  parameter int NUM_CH     = 2,
  parameter int WORD_BYTES = 4,
  parameter int NUM_CTRL   = 4
) (
  input  wire logic                           clk,
  input  wire logic                           rst_n,
  register_bank_multi_nco_if.slave            bus,
  input  wire logic                           sync_tick,
  output logic [NUM_CH*WORD_BYTES*8-1:0]      phase_words,
  output logic [NUM_CH-1:0]                   phase_update,
  output logic [NUM_CTRL*8-1:0]               ctrl_regs,
  output logic [NUM_CTRL-1:0]                 ctrl_update
);

  localparam int         W           = WORD_BYTES * 8;
  localparam int         SW          = W - 8;  // staged upper bytes per channel
  localparam logic [7:0] CTRL_BASE   = 8'(NUM_CH * WORD_BYTES);
  localparam logic [7:0] STATUS_ADDR = 8'(NUM_CH * WORD_BYTES + NUM_CTRL);

  generate
    if ((NUM_CH * WORD_BYTES + NUM_CTRL + 1 > 256) || (WORD_BYTES < 2) ||
        (NUM_CH < 1) || (NUM_CTRL < 1)) begin : g_cfg_error
      $error("register_bank_multi_nco: address map does not fit 8-bit space");
    end
  endgenerate

  logic [NUM_CH-1:0][SW-1:0]  stage_q, stage_d;
  logic [NUM_CH-1:0][W-1:0]   phase_q, phase_d;
  logic [NUM_CTRL-1:0][7:0]   ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]          phase_upd_q, phase_upd_d;
  logic [NUM_CTRL-1:0]        ctrl_upd_q, ctrl_upd_d;
  logic [7:0]                 data_q, data_d;
  logic [7:0]                 status_w;

`ifdef SYNC_COMMIT_EN
  logic [NUM_CH-1:0][W-1:0]   pend_word_q, pend_word_d;
  logic [NUM_CH-1:0]          pend_q, pend_d;

  generate
    if (NUM_CH >= 8) begin : g_status_wide
      assign status_w = pend_q[7:0];
    end else begin : g_status_narrow
      assign status_w = {{(8 - NUM_CH){1'b0}}, pend_q};
    end
  endgenerate
`else
  logic unused_sync_tick;
  assign unused_sync_tick = sync_tick;
  assign status_w         = 8'h00;
`endif

  always_comb begin
    stage_d     = stage_q;
    phase_d     = phase_q;
    ctrl_d      = ctrl_q;
    phase_upd_d = '0;
    ctrl_upd_d  = '0;
    data_d      = 8'h00;
`ifdef SYNC_COMMIT_EN
    pend_word_d = pend_word_q;
    pend_d      = pend_q;
`endif

    // Read mux: phase bytes return the committed word, byte 0 is the MSB.
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (bus.addr == 8'(c * WORD_BYTES + b)) begin
          data_d = phase_q[c][W-1-8*b -: 8];
        end
      end
    end
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (bus.addr == CTRL_BASE + 8'(k)) begin
        data_d = ctrl_q[k];
      end
    end
    if (bus.addr == STATUS_ADDR) begin
      data_d = status_w;
    end

`ifdef SYNC_COMMIT_EN
    // Tick is evaluated before the write so that an LSB write in the same
    // cycle commits the older pending word and leaves the new one pending.
    if (sync_tick) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pend_q[c]) begin
          phase_d[c]     = pend_word_q[c];
          pend_d[c]      = 1'b0;
          phase_upd_d[c] = 1'b1;
        end
      end
    end
`endif

    if (bus.writeEn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int b = 0; b < WORD_BYTES - 1; b++) begin
          if (bus.addr == 8'(c * WORD_BYTES + b)) begin
            stage_d[c][SW-1-8*b -: 8] = bus.dataIn;
          end
        end
        // Staging is left intact so an LSB-only rewrite reuses the upper bytes.
        if (bus.addr == 8'(c * WORD_BYTES + WORD_BYTES - 1)) begin
`ifdef SYNC_COMMIT_EN
          pend_word_d[c] = {stage_q[c], bus.dataIn};
          pend_d[c]      = 1'b1;
`else
          phase_d[c]     = {stage_q[c], bus.dataIn};
          phase_upd_d[c] = 1'b1;
`endif
        end
      end
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (bus.addr == CTRL_BASE + 8'(k)) begin
          ctrl_d[k]     = bus.dataIn;
          ctrl_upd_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      phase_q     <= '0;
      ctrl_q      <= '0;
      phase_upd_q <= '0;
      ctrl_upd_q  <= '0;
      data_q      <= 8'h00;
`ifdef SYNC_COMMIT_EN
      pend_word_q <= '0;
      pend_q      <= '0;
`endif
    end else begin
      stage_q     <= stage_d;
      phase_q     <= phase_d;
      ctrl_q      <= ctrl_d;
      phase_upd_q <= phase_upd_d;
      ctrl_upd_q  <= ctrl_upd_d;
      data_q      <= data_d;
`ifdef SYNC_COMMIT_EN
      pend_word_q <= pend_word_d;
      pend_q      <= pend_d;
`endif
    end
  end

  assign bus.dataOut  = data_q;
  assign phase_words  = phase_q;
  assign phase_update = phase_upd_q;
  assign ctrl_regs    = ctrl_q;
  assign ctrl_update  = ctrl_upd_q;

endmodule
`default_nettype wire

// File: doc/register_bank_multi_nco.md
Name: register_bank_multi_nco

Overview:
- Parametrised successor of the I2C slave register file.
- Holds NUM_CH NCO phase words, each WORD_BYTES bytes, written byte-wise over I2C. Each word is committed atomically when its LSB byte is written.
- Also holds NUM_CTRL 8-bit control registers, each with a one-cycle update strobe, plus a read-only status register.
- Sits between the i2cSlave byte interface and the DDC/DUC datapath. Every value that is written can be read back.

Parameters:
- NUM_CH, 2, number of NCO phase-word channels.
- WORD_BYTES, 4, bytes per phase word; word width is WORD_BYTES*8.
- NUM_CTRL, 4, number of 8-bit control registers.
- Constraint: NUM_CH*WORD_BYTES + NUM_CTRL + 1 <= 256; elaboration error otherwise.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  8  register address from the I2C slave.
- dataIn  in  8  write data.
- writeEn  in  1  write strobe; one write per high cycle.
- dataOut  out  8  registered read data.
- sync_tick  in  1  commit boundary, e.g. a frame or sample strobe; ignored unless SYNC_COMMIT_EN is defined.
- phase_words  out  NUM_CH*WORD_BYTES*8  committed phase words; channel c occupies bits [(c+1)*W-1 : c*W], with W = WORD_BYTES*8.
- phase_update  out  NUM_CH  one-cycle pulse when channel c commits.
- ctrl_regs  out  NUM_CTRL*8  control registers; register k occupies bits [k*8+7 : k*8].
- ctrl_update  out  NUM_CTRL  one-cycle pulse when control register k is written.

Behaviour:

Address map:
- Phase bytes: addr = c*WORD_BYTES + b, with b = 0 the MSB and b = WORD_BYTES-1 the LSB.
- CTRL_BASE = NUM_CH*WORD_BYTES. Control register k is at CTRL_BASE + k.
- STATUS_ADDR = CTRL_BASE + NUM_CTRL.
- All other addresses are unmapped.

Reset:
- rst_n low clears asynchronously: dataOut, all staging bytes, phase_words, ctrl_regs, pending flags, phase_update and ctrl_update. All clear to 0.
- Reset asserted mid-sequence discards any partially staged word.

Reads:
- dataOut is registered from addr every cycle, giving 1-cycle latency.
- A phase byte reads the committed value, not the staged one.
- Control registers read their current value.
- STATUS_ADDR reads pending[NUM_CH-1:0], zero-padded to 8 bits. If NUM_CH > 8, only pending[7:0] is visible.
- Unmapped addresses read 0x00.

Writes to phase bytes 0..WORD_BYTES-2:
- The byte is stored into that channel's staging register.
- No output changes.

Write to the LSB byte:
- The candidate word is {staged bytes, dataIn}.
- Commit behaviour depends on SYNC_COMMIT_EN (see Optional Feature).

Write to a control register:
- ctrl_regs[k] is updated on the write edge.
- ctrl_update[k] is high for exactly the following cycle.

Other writes:
- Writes to STATUS_ADDR or unmapped addresses are ignored.

Back-to-back and repeated writes:
- Back-to-back writes on consecutive cycles are all honoured.
- Staging registers retain their contents after a commit, so rewriting only the LSB recommits with the old upper bytes.
- All update strobes are single-cycle. There is no strobe when writeEn is low.

Optional Feature:

Macro: SYNC_COMMIT_EN

Undefined:
- An LSB write loads phase_words[c] on the same edge.
- phase_update[c] is high the following cycle.
- pending always reads 0.
- sync_tick is unused.

Defined:
- An LSB write loads the candidate into pend_word[c] and sets pending[c].
- In a cycle with sync_tick high, every channel with pending set does the following on that edge:
  - copies pend_word to phase_words;
  - clears pending;
  - pulses phase_update the next cycle.
- This gives coherent multi-channel retune.
- A second LSB write before the tick overwrites pend_word, which is last-write-wins.
- An LSB write in the same cycle as sync_tick:
  - the previously pending value, if any, commits on that tick;
  - the new value is captured into pend_word;
  - pending[c] remains 1 until the next tick.
- sync_tick with nothing pending has no effect.

Test Plan:
1. Reset, then read every mapped address and 0xFF -> dataOut = 0x00 one cycle after each addr; all strobes 0.
2. Defaults, macro off. Write ch1 bytes 0x12, 0x34, 0x56, 0x78 at addr 4..7 -> phase_words[63:32] unchanged until the addr-7 write edge, then 0x12345678. phase_update = 2'b10 for one cycle. Reading addr 5 returns 0x34.
3. Write 0xA5 to addr 9, i.e. ctrl[1] -> ctrl_regs[15:8] = 0xA5; ctrl_update = 4'b0010 for one cycle. Then write to addr 0x20 -> nothing changes.
4. Macro on. Write ch0 = 0x01020304 and ch1 = 0x0A0B0C0D, no tick -> phase_words unchanged; STATUS (addr 12) = 0x03. Pulse sync_tick -> both words update on the same edge; phase_update = 2'b11 for one cycle; STATUS = 0x00.
5. Macro on. ch0 pending 0x11111111; LSB write producing 0x22222222 in the same cycle as sync_tick -> phase_words[31:0] = 0x11111111 and pending[0] = 1. At the next tick -> phase_words[31:0] = 0x22222222.
6. Write ch0 bytes 0..2, assert rst_n low, release, then write only the LSB 0x44 -> phase_words[31:0] = 0x00000044.
